// File: rtl/evb_result_writer_if.sv
// Evaluator-side and output-FIFO-side signals of the EVB result writer.
// The writer is the slave; the evaluator/FIFO environment is the master.
interface evb_result_writer_if;
  logic        start_wr;
  logic [4:0]  b;
  logic        result_valid;
  logic [31:0] result;
  logic [31:0] status;
  logic        done_evb;
  logic        fifo_full;
  logic        wr_en_out;
  logic [31:0] data_out;
  logic        done_out;
  logic        busy;

  modport master (
    output start_wr, b, result_valid, result, status, done_evb, fifo_full,
    input  wr_en_out, data_out, done_out, busy
  );

  modport slave (
    input  start_wr, b, result_valid, result, status, done_evb, fifo_full,
    output wr_en_out, data_out, done_out, busy
  );
endinterface

// File: rtl/evb_result_writer.sv
// Buffers per-polynomial EVB results in a circular queue, drains them into the
// output FIFO under back-pressure, then appends one summary status word.
module evb_result_writer #(
  parameter int queue_depth = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_instr,
  evb_result_writer_if.slave io
);
  localparam int          AW    = $clog2(queue_depth);
  localparam logic [AW:0] QFULL = queue_depth[AW:0];

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    DRAIN   = 3'd2,
    STATUS  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [queue_depth];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_nxt;
  logic [4:0]    b_lat;
  logic [5:0]    rcv, rcv_nxt;
  logic          mismatch, overflow, fs_set;
  logic [29:0]   first_status;
  logic          wr_en_r, wr_en_d, done_r, done_d;
  logic [31:0]   data_r, data_d;
  logic          active, pop, enq_req, drop, enq;
  logic [31:0]   summary;

  assign active    = (state == COLLECT) || (state == DRAIN);
  assign pop       = active && (count != '0) && !io.fifo_full;
  assign enq_req   = active && io.result_valid;
  // A full queue still accepts a result when the head leaves in the same cycle.
  assign drop      = enq_req && (count == QFULL) && !pop;
  assign enq       = enq_req && !drop;
  assign count_nxt = count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};
  assign rcv_nxt   = (enq_req && rcv != 6'h3f) ? rcv + 6'd1 : rcv;
  assign summary   = {overflow, mismatch, first_status};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            state <= IDLE;
    else if (!rst_instr) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en_d   = 1'b0;
    data_d    = data_r;
    done_d    = 1'b0;
    case (state)
      IDLE:    if (io.start_wr) state_nxt = COLLECT;
      COLLECT: if (io.done_evb) state_nxt = DRAIN;
      // Leave only once nothing is left, including a late result arriving now.
      DRAIN:   if (count_nxt == '0) state_nxt = STATUS;
      STATUS:  if (!io.fifo_full) begin
        wr_en_d   = 1'b1;
        data_d    = summary;
        state_nxt = DONE;
      end
      DONE: begin
        done_d    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (pop) begin
      wr_en_d = 1'b1;
      data_d  = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= io.result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0;
      b_lat <= '0; rcv <= '0; mismatch <= 1'b0; overflow <= 1'b0;
      fs_set <= 1'b0; first_status <= '0;
      wr_en_r <= 1'b0; data_r <= '0; done_r <= 1'b0;
    end else if (!rst_instr) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0;
      b_lat <= '0; rcv <= '0; mismatch <= 1'b0; overflow <= 1'b0;
      fs_set <= 1'b0; first_status <= '0;
      wr_en_r <= 1'b0; data_r <= '0; done_r <= 1'b0;
    end else begin
      wr_en_r <= wr_en_d;
      data_r  <= data_d;
      done_r  <= done_d;
      count   <= count_nxt;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (state == IDLE && io.start_wr) begin
        b_lat        <= io.b;
        rcv          <= '0;
        mismatch     <= 1'b0;
        overflow     <= 1'b0;
        fs_set       <= 1'b0;
        first_status <= '0;
      end else begin
        rcv <= rcv_nxt;
        if (drop) overflow <= 1'b1;
        if (enq_req && io.status != '0 && !fs_set) begin
          fs_set       <= 1'b1;
          first_status <= io.status[29:0];
        end
        // Counts this cycle's result too, so a last result coinciding with done_evb is included.
        if (state == COLLECT && io.done_evb) mismatch <= (rcv_nxt != {1'b0, b_lat});
      end
    end
  end

  assign io.wr_en_out = wr_en_r;
  assign io.data_out  = data_r;
  assign io.done_out  = done_r;
  assign io.busy      = (state != IDLE);
endmodule

// File: tb/tb_evb_result_writer.sv
// Self-checking bench for evb_result_writer: randomized batches against a
// queue-level reference model, plus directed boundary scenarios.
module tb_evb_result_writer;
  localparam int QD = 32;

  logic clk = 1'b0;
  logic rst, rst_instr;
  evb_result_writer_if io();

  evb_result_writer #(.queue_depth(QD)) dut (
    .clk(clk), .rst(rst), .rst_instr(rst_instr), .io(io)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, viol = 0, first_res_cyc = 0;
  logic ff_edge;
  logic [31:0] wq[$];
  int          wcyc[$];
  logic [31:0] sres[$], sst[$], exp_q[$];

  // Observe FIFO writes and done pulses just after each rising edge.
  always @(posedge clk) begin
    ff_edge = io.fifo_full;
    #1;
    cyc++;
    if (io.wr_en_out === 1'b1) begin
      wq.push_back(io.data_out);
      wcyc.push_back(cyc);
      if (ff_edge) viol++;
    end
    if (io.done_out === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference: kept results in arrival order, then {overflow, mismatch, first nonzero status[29:0]}.
  task automatic build_expected(input int bb, input int keep);
    logic [31:0] fs;
    logic ovf, mis;
    fs = '0;
    exp_q.delete();
    foreach (sst[i]) if (fs == 0 && sst[i] != 0) fs = sst[i];
    for (int i = 0; i < sres.size() && i < keep; i++) exp_q.push_back(sres[i]);
    ovf = (sres.size() > keep);
    mis = (sres.size() != bb);
    exp_q.push_back({ovf, mis, fs[29:0]});
  endtask

  task automatic drive_batch(input int bb, input int ff_pct, input int gap_max, input bit hold_full,
                             input int hold_extra, input bit done_with_last, input bit stray_start);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    io.start_wr = 1'b1; io.b = bb[4:0]; io.fifo_full = hold_full;
    @(negedge clk);
    io.start_wr = 1'b0;
    for (int i = 0; i < sres.size(); i++) begin
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) begin
        io.fifo_full = hold_full || (int'($urandom_range(99, 0)) < ff_pct);
        @(negedge clk);
      end
      io.fifo_full    = hold_full || (int'($urandom_range(99, 0)) < ff_pct);
      io.result_valid = 1'b1;
      io.result       = sres[i];
      io.status       = sst[i];
      io.done_evb     = done_with_last && (i == sres.size() - 1);
      if (stray_start && i == 0) begin
        io.start_wr = 1'b1;
        io.b        = ~bb[4:0];
      end
      if (i == 0) first_res_cyc = cyc + 1;
      @(negedge clk);
      io.result_valid = 1'b0; io.done_evb = 1'b0; io.start_wr = 1'b0;
      io.result = $urandom; io.status = $urandom;
    end
    if (!done_with_last || sres.size() == 0) begin
      io.done_evb  = 1'b1;
      io.fifo_full = hold_full || (int'($urandom_range(99, 0)) < ff_pct);
      @(negedge clk);
      io.done_evb = 1'b0;
    end
    repeat (hold_extra) @(negedge clk);
    for (int t = 0; t < 400 && done_cnt == d0; t++) begin
      io.fifo_full = (int'($urandom_range(99, 0)) < ff_pct);
      @(negedge clk);
    end
    io.fifo_full = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (io.wr_en_out !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", io.wr_en_out); end
    vectors++; if (io.data_out !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", io.data_out); end
    vectors++; if (io.done_out !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", io.done_out); end
    vectors++; if (io.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", io.busy); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int d0;
    logic [31:0] got;
    sres = {32'h11, 32'h22, 32'h33};
    sst  = {32'h0, 32'h0, 32'h0};
    build_expected(3, QD);
    wq.delete(); wcyc.delete(); d0 = done_cnt;
    drive_batch(3, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    vectors++; if (wq.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_len: got %0d want %0d", wq.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL basic_word[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
    vectors++; if (wcyc.size() < 4 || wcyc[0] != first_res_cyc + 1) begin
      miscompares++; $display("FAIL basic_latency: got %0d want %0d", (wcyc.size() > 0) ? wcyc[0] : -1, first_res_cyc + 1); end
    vectors++; if (wcyc.size() < 4 || wcyc[2] != wcyc[0] + 2) begin
      miscompares++; $display("FAIL basic_throughput: got %0d want %0d", (wcyc.size() > 2) ? wcyc[2] : -1, (wcyc.size() > 0) ? wcyc[0] + 2 : -1); end
    vectors++; if (wcyc.size() == 0 || done_cyc != wcyc[wcyc.size()-1] + 1) begin
      miscompares++; $display("FAIL basic_done_timing: got %0d want last write + 1", done_cyc); end
    vectors++; if (io.busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b want 0", io.busy); end
  endtask

  task automatic test_backpressure();
    int v0;
    logic [31:0] got;
    sres.delete(); sst.delete();
    for (int i = 0; i < 4; i++) begin sres.push_back($urandom); sst.push_back(32'h0); end
    build_expected(4, QD);
    wq.delete(); wcyc.delete(); v0 = viol;
    drive_batch(4, 0, 0, 1'b1, 5, 1'b0, 1'b0);
    vectors++; if (wq.size() != exp_q.size()) begin miscompares++; $display("FAIL bp_len: got %0d want %0d", wq.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL bp_word[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    vectors++; if (viol != v0) begin miscompares++; $display("FAIL bp_write_while_full: got %0d want 0", viol - v0); end
  endtask

  task automatic test_status_word();
    int bb, n, d0;
    bit dwl;
    logic [31:0] got;
    for (int k = 0; k < 5; k++) begin
      sres.delete(); sst.delete();
      case (k)
        0: begin bb = 3; n = 3; dwl = 1'b0; end
        1: begin bb = 5; n = 4; dwl = 1'b1; end
        2: begin bb = 2; n = 2; dwl = 1'b1; end
        3: begin bb = 0; n = 0; dwl = 1'b0; end
        default: begin bb = 1; n = 1; dwl = 1'b0; end
      endcase
      for (int i = 0; i < n; i++) begin sres.push_back($urandom); sst.push_back(32'h0); end
      if (k == 0) begin sst[1] = 32'h5; sst[2] = 32'h9; end
      if (k == 4) sst[0] = 32'h4000_0003;
      build_expected(bb, QD);
      wq.delete(); wcyc.delete(); d0 = done_cnt;
      drive_batch(bb, 0, 1, 1'b0, 0, dwl, 1'b0);
      vectors++; if (wq.size() != exp_q.size()) begin miscompares++; $display("FAIL status%0d_len: got %0d want %0d", k, wq.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
        vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL status%0d_word[%0d]: got %h want %h", k, i, got, exp_q[i]); end
      end
      vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL status%0d_done: got %0d want 1", k, done_cnt - d0); end
    end
  endtask

  task automatic test_overflow();
    int v0;
    logic [31:0] got;
    sres.delete(); sst.delete();
    for (int i = 0; i < QD + 1; i++) begin sres.push_back($urandom); sst.push_back(32'h0); end
    build_expected(31, QD);
    wq.delete(); wcyc.delete(); v0 = viol;
    drive_batch(31, 0, 0, 1'b1, 2, 1'b0, 1'b0);
    vectors++; if (wq.size() != exp_q.size()) begin miscompares++; $display("FAIL ovf_len: got %0d want %0d", wq.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL ovf_word[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    vectors++; if (viol != v0) begin miscompares++; $display("FAIL ovf_write_while_full: got %0d want 0", viol - v0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    @(negedge clk); io.start_wr = 1'b1; io.b = 5'd3; io.fifo_full = 1'b0;
    @(negedge clk); io.start_wr = 1'b0; io.result_valid = 1'b1; io.result = 32'hA1; io.status = 0;
    @(negedge clk); io.result = 32'hB2;
    @(negedge clk); io.result = 32'hC3; io.fifo_full = 1'b1;
    @(negedge clk); io.result_valid = 1'b0; io.done_evb = 1'b1;
    @(negedge clk); io.done_evb = 1'b0;
    vectors++; if (io.busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before: got %b want 1", io.busy); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (io.wr_en_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_wr_en: got %b want 0", io.wr_en_out); end
    vectors++; if (io.data_out !== 32'h0) begin miscompares++; $display("FAIL rstmid_data: got %h want 0", io.data_out); end
    vectors++; if (io.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", io.busy); end
    vectors++; if (io.done_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %b want 0", io.done_out); end
    @(negedge clk); rst = 1'b1; io.fifo_full = 1'b0;
    sres = {32'h7}; sst = {32'h0};
    build_expected(1, QD);
    wq.delete(); wcyc.delete();
    drive_batch(1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    vectors++; if (wq.size() != exp_q.size()) begin miscompares++; $display("FAIL rstmid_len: got %0d want %0d", wq.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_word[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_instr_clear();
    logic [31:0] got;
    @(negedge clk); io.start_wr = 1'b1; io.b = 5'd2; io.fifo_full = 1'b1;
    @(negedge clk); io.start_wr = 1'b0; io.result_valid = 1'b1; io.result = 32'hDEAD; io.status = 32'h3;
    @(negedge clk); io.result_valid = 1'b0; rst_instr = 1'b0;
    @(posedge clk); #1;
    vectors++; if (io.busy !== 1'b0) begin miscompares++; $display("FAIL iclr_busy: got %b want 0", io.busy); end
    vectors++; if (io.wr_en_out !== 1'b0) begin miscompares++; $display("FAIL iclr_wr_en: got %b want 0", io.wr_en_out); end
    @(negedge clk); rst_instr = 1'b1; io.fifo_full = 1'b0;
    sres = {32'h55}; sst = {32'h0};
    build_expected(1, QD);
    wq.delete(); wcyc.delete();
    drive_batch(1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    foreach (exp_q[i]) begin
      got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL iclr_word[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    for (int k = 0; k < 2; k++) begin
      sres.delete(); sst.delete();
      for (int i = 0; i < 31; i++) begin sres.push_back($urandom); sst.push_back(32'h0); end
      build_expected(31, QD);
      wq.delete(); wcyc.delete();
      drive_batch(31, 0, 0, 1'b0, 0, 1'b1, 1'b0);
      vectors++; if (wq.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b%0d_len: got %0d want %0d", k, wq.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
        vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL b2b%0d_word[%0d]: got %h want %h", k, i, got, exp_q[i]); end
      end
      vectors++; if (wcyc.size() < 31 || wcyc[30] != first_res_cyc + 31) begin
        miscompares++; $display("FAIL b2b%0d_rate: got %0d want %0d", k, (wcyc.size() > 30) ? wcyc[30] : -1, first_res_cyc + 31); end
    end
  endtask

  task automatic test_random();
    int bb, n, d0, v0;
    bit dwl, stray;
    logic [31:0] got;
    for (int k = 0; k < 10; k++) begin
      sres.delete(); sst.delete();
      bb = $urandom_range(31, 0);
      n  = bb + int'($urandom_range(2, 0)) - 1;
      if (n < 0) n = 0;
      if (n > 31) n = 31;
      for (int i = 0; i < n; i++) begin
        sres.push_back($urandom);
        sst.push_back(($urandom_range(3, 0) == 0) ? $urandom : 32'h0);
      end
      dwl = $urandom_range(1, 0); stray = $urandom_range(1, 0);
      build_expected(bb, QD);
      wq.delete(); wcyc.delete(); d0 = done_cnt; v0 = viol;
      drive_batch(bb, 35, 2, 1'b0, 0, dwl, stray);
      vectors++; if (wq.size() != exp_q.size()) begin miscompares++; $display("FAIL rnd%0d_len: got %0d want %0d", k, wq.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
        vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL rnd%0d_word[%0d]: got %h want %h", k, i, got, exp_q[i]); end
      end
      vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL rnd%0d_done: got %0d want 1", k, done_cnt - d0); end
      vectors++; if (viol != v0) begin miscompares++; $display("FAIL rnd%0d_write_while_full: got %0d want 0", k, viol - v0); end
      vectors++; if (wcyc.size() == 0 || done_cyc != wcyc[wcyc.size()-1] + 1) begin
        miscompares++; $display("FAIL rnd%0d_done_timing: got %0d want last write + 1", k, done_cyc); end
    end
  endtask

  initial begin
    rst = 1'b1; rst_instr = 1'b1;
    io.start_wr = 1'b0; io.b = '0; io.result_valid = 1'b0; io.result = '0;
    io.status = '0; io.done_evb = 1'b0; io.fifo_full = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_status_word();
    test_overflow();
    test_reset_mid();
    test_instr_clear();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/evb_result_writer.md
# evb_result_writer

Downstream of the batch evaluator (EVB) stage. Captures each per-polynomial 32-bit result as the evaluator completes it, buffers it in a small internal queue, and pushes it into the output FIFO under `full` back-pressure. After the batch ends it appends one summary status word, then pulses `done_out`. The evaluator cannot stall, so this block absorbs output-FIFO back-pressure without losing results.

## Interface

Parameters:
- `queue_depth`, default 32: internal result queue entries, power of two, must be at least 32 (b max is 31).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rst_instr`  in  1  synchronous active-low per-instruction clear; same effect as `rst`, applied at the clock edge.
- `start_wr`  in  1  one-cycle pulse: a new batch begins; samples `b`.
- `b`  in  5  number of results expected in this batch.
- `result_valid`  in  1  one-cycle pulse per completed evaluation; driven by EVB `done_evp`.
- `result`  in  32  evaluation result; valid with `result_valid`.
- `status`  in  32  evaluation status; valid with `result_valid`; 0 means OK.
- `done_evb`  in  1  one-cycle pulse: evaluator finished the batch.
- `fifo_full`  in  1  output FIFO full.
- `wr_en_out`  out  1  output FIFO write strobe.
- `data_out`  out  32  output FIFO write data.
- `done_out`  out  1  one-cycle pulse: batch fully written.
- `busy`  out  1  high from `start_wr` until `done_out`.

## Operation

- The queue is a circular buffer with read pointer, write pointer and count. Pointers wrap modulo `queue_depth`.
- A word is enqueued on every `result_valid` while in COLLECT or DRAIN.
- Head dequeue rule: when count > 0 and `fifo_full` = 0, the block registers `wr_en_out` = 1 and `data_out` = head in that cycle, and pops the head.
- If enqueue and dequeue happen in the same cycle, count is unchanged.
- First-error capture:
  - `first_status` clears to 0 at `start_wr`.
  - On each `result_valid` with `status` != 0, `first_status` loads `status` only if it is still 0.
- Summary word:
  - bits [29:0] = `first_status`[29:0].
  - bit 30 = count mismatch: number of results received != `b` at `done_evb`.
  - bit 31 = overflow: any result dropped.
- Overflow: `result_valid` while the queue is full and no pop occurs that cycle. The result is dropped, an internal sticky flag is set, and the write pointer does not move.

State machine, encoded in 3 bits:
- IDLE: on `start_wr`, latch `b`, clear the received counter, flags and `first_status`; go to COLLECT.
- COLLECT: enqueue and drain. On `done_evb`, latch the mismatch flag; go to DRAIN.
- DRAIN: keep draining. Go to STATUS when count = 0.
- STATUS: when `fifo_full` = 0, write the summary word (`wr_en_out` = 1); go to DONE. Otherwise wait.
- DONE: `done_out` = 1 for one cycle; go to IDLE.
- `start_wr` outside IDLE is ignored. `result_valid` in IDLE, STATUS or DONE is ignored.
- If `b` = 0: the summary is written after `done_evb` with only the mismatch and overflow bits possibly set.

## Timing

- Reset values (both `rst` and `rst_instr`): state IDLE, `wr_en_out` = 0, `data_out` = 0, `done_out` = 0, `busy` = 0, pointers, count and flags = 0.
- `rst` asserted mid-batch: all outputs go to reset values immediately (asynchronously); queue contents are discarded.
- Latency: a `result_valid` at edge n produces `wr_en_out` with that word at edge n+1 when the queue was empty and `fifo_full` = 0.
- Throughput: one word per cycle when `fifo_full` = 0.
- `wr_en_out` is never asserted in a cycle where `fifo_full` was 1 at the preceding edge.
- `done_evb` and the last `result_valid` in the same cycle: the result is counted and enqueued before mismatch is evaluated.
- `done_out` occurs one cycle after the summary write. `busy` falls with `done_out`.

## Test plan

- b=3, results 0x11, 0x22, 0x33 with status 0, `fifo_full` = 0 → FIFO receives 0x11, 0x22, 0x33, 0x00000000 in order, then `done_out` pulses once.
- b=4, `fifo_full` held high for 10 cycles during the batch → all 4 results are preserved in order, followed by summary 0; no write occurs while full.
- b=3, statuses 0, 0x5, 0x9 → summary word = 0x00000005.
- b=5, only 4 `result_valid` pulses before `done_evb` → summary word bit 30 = 1 (0x40000000).
- `fifo_full` held high with 33 results pushed (b=31; `queue_depth` forced small, e.g. 4, in a directed variant) → summary bit 31 = 1 and dropped words are absent from the output.
- `rst` pulsed low mid-DRAIN with 2 words queued → outputs are 0 immediately; a new batch with b=1, result 0x7 then yields 0x7, 0x0.
